// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order prediction queue matched against execute outcomes; stats counters under BRU_STATS_EN
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pred_valid,
  input  logic                       pred_taken,
  input  logic [PC_W-1:0]            pred_pc,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       res_ready,
  output logic                       upd_valid,
  output logic                       upd_taken,
  output logic [PC_W-1:0]            upd_pc,
  output logic                       mispredict,
  output logic [$clog2(DEPTH):0]     inflight,
  output logic [CNT_W-1:0]           br_count,
  output logic [CNT_W-1:0]           mis_count
);
  localparam int AW = $clog2(DEPTH);
  logic [PC_W:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] cnt;
  logic push, pop, mis;
  assign inflight = cnt;
  assign pred_ready = cnt != (AW+1)'(DEPTH);
  assign res_ready = cnt != '0;
  assign push = pred_valid && pred_ready;
  assign pop = res_valid && res_ready;
  assign mis = pop && (mem[rd_ptr][PC_W] ^ res_taken);
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pred_taken, pred_pc};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
      upd_valid <= 1'b0;
      upd_taken <= 1'b0;
      upd_pc <= '0;
      mispredict <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= mis ? wr_ptr + AW'(push) : rd_ptr + AW'(pop);
      cnt <= mis ? '0 : cnt + (AW+1)'(push) - (AW+1)'(pop);
      upd_valid <= pop;
      upd_taken <= pop && res_taken;
      upd_pc <= pop ? mem[rd_ptr][PC_W-1:0] : '0;
      mispredict <= mis;
    end
  end
`ifdef BRU_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count <= '0;
      mis_count <= '0;
    end else begin
      if (pop && !(&br_count)) br_count <= br_count + 1'b1;
      if (mis && !(&mis_count)) mis_count <= mis_count + 1'b1;
    end
  end
`else
  assign br_count = '0;
  assign mis_count = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: table, directed and random checks of branch_resolve_unit against a queue model
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;
  localparam int PC_W = 8;
  localparam int CNT_W = 16;
`ifdef BRU_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic pred_valid = 0, pred_taken = 0, res_valid = 0, res_taken = 0;
  logic [PC_W-1:0] pred_pc = '0;
  logic pred_ready, res_ready, upd_valid, upd_taken, mispredict;
  logic [PC_W-1:0] upd_pc;
  logic [$clog2(DEPTH):0] inflight;
  logic [CNT_W-1:0] br_count, mis_count;
  branch_resolve_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .pred_ready(pred_ready), .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc), .mispredict(mispredict),
    .inflight(inflight), .br_count(br_count), .mis_count(mis_count)
  );
  always #5 clk = ~clk;
  typedef struct { logic t; logic [PC_W-1:0] pc; } ent_t;
  typedef struct {
    logic pv, pt; logic [PC_W-1:0] pc; logic rv, rt;
    logic uv; logic [PC_W-1:0] upc; logic mis; int inf;
  } vec_t;
  ent_t q[$];
  vec_t tbl[17];
  int checks = 0, errors = 0;
  logic exp_uv, exp_ut, exp_mis;
  logic [PC_W-1:0] exp_upc;
  int mbr = 0, mmis = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic chk_cnt();
    chk("br_count", br_count, STATS ? mbr : 0);
    chk("mis_count", mis_count, STATS ? mmis : 0);
  endtask
  task automatic cyc(input logic pv, input logic pt, input logic [PC_W-1:0] pc, input logic rv, input logic rt);
    logic pu, po, m;
    ent_t h;
    @(negedge clk);
    pred_valid = pv; pred_taken = pt; pred_pc = pc; res_valid = rv; res_taken = rt;
    #1;
    chk("pred_ready", pred_ready, q.size() != DEPTH);
    chk("res_ready", res_ready, q.size() != 0);
    pu = pv && q.size() != DEPTH;
    po = rv && q.size() != 0;
    m = 0;
    exp_uv = po;
    if (po) begin
      h = q.pop_front();
      m = h.t != rt;
      exp_ut = rt;
      exp_upc = h.pc;
      if (mbr != 65535) mbr++;
      if (m && mmis != 65535) mmis++;
    end
    exp_mis = m;
    if (pu) q.push_back('{pt, pc});
    if (m) q.delete();
    @(posedge clk);
    #1;
    pred_valid = 0; res_valid = 0;
    chk("upd_valid", upd_valid, exp_uv);
    chk("mispredict", mispredict, exp_mis);
    if (exp_uv) begin
      chk("upd_taken", upd_taken, exp_ut);
      chk("upd_pc", upd_pc, exp_upc);
    end
    chk("inflight", inflight, q.size());
    chk_cnt();
  endtask
  task automatic reset_check();
    chk("rst_inflight", inflight, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_upd_taken", upd_taken, 0);
    chk("rst_upd_pc", upd_pc, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_pred_ready", pred_ready, 1);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_br_count", br_count, 0);
    chk("rst_mis_count", mis_count, 0);
  endtask
  initial begin
    tbl[0]  = '{1,1,8'h12,0,0, 0,0,0,1};
    tbl[1]  = '{0,0,0,1,1,     1,8'h12,0,0};
    tbl[2]  = '{1,1,1,0,0,     0,0,0,1};
    tbl[3]  = '{1,1,2,0,0,     0,0,0,2};
    tbl[4]  = '{1,1,3,0,0,     0,0,0,3};
    tbl[5]  = '{1,1,4,0,0,     0,0,0,4};
    tbl[6]  = '{1,1,5,1,1,     1,1,0,3};
    tbl[7]  = '{0,0,0,1,0,     1,2,1,0};
    tbl[8]  = '{0,0,0,1,0,     0,0,0,0};
    tbl[9]  = '{1,1,1,0,0,     0,0,0,1};
    tbl[10] = '{1,1,2,0,0,     0,0,0,2};
    tbl[11] = '{1,0,3,0,0,     0,0,0,3};
    tbl[12] = '{0,0,0,1,0,     1,1,1,0};
    tbl[13] = '{1,0,7,0,0,     0,0,0,1};
    tbl[14] = '{1,1,8,0,0,     0,0,0,2};
    tbl[15] = '{1,1,9,1,0,     1,7,0,2};
    tbl[16] = '{1,1,10,1,0,    1,8,1,0};
    #12;
    reset_check();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].pv, tbl[i].pt, tbl[i].pc, tbl[i].rv, tbl[i].rt);
      chk($sformatf("tbl%0d_upd_valid", i), upd_valid, tbl[i].uv);
      chk($sformatf("tbl%0d_inflight", i), inflight, tbl[i].inf);
      if (tbl[i].uv) begin
        chk($sformatf("tbl%0d_upd_pc", i), upd_pc, tbl[i].upc);
        chk($sformatf("tbl%0d_mispredict", i), mispredict, tbl[i].mis);
      end
    end
    begin
      int base_br = mbr, base_mis = mmis;
      for (int i = 0; i < 3; i++) cyc(1, i[0], 8'(8'h40 + i), 0, 0);
      for (int i = 3; i < 6; i++) cyc(1, i[0], 8'(8'h40 + i), 1, q[0].t);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, q[0].t);
      chk("wrap_br_delta", br_count, STATS ? base_br + 6 : 0);
      chk("wrap_mis_delta", mis_count, STATS ? base_mis : 0);
      chk("wrap_empty", inflight, 0);
    end
    for (int i = 0; i < 400; i++) begin
      logic rt;
      rt = (q.size() != 0 && $urandom_range(3) != 0) ? q[0].t : 1'($urandom);
      cyc(1'($urandom_range(2) != 0), 1'($urandom), 8'($urandom), 1'($urandom_range(1)), rt);
    end
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'(8'h70 + i), 0, 0);
    cyc(0, 0, 0, 1, 1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    q.delete();
    mbr = 0;
    mmis = 0;
    reset_check();
    @(negedge clk);
    rst = 0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 8'h55, 0, 0);
    cyc(0, 0, 0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Receiving end of the branch predictor interface. It queues the predictions the 1-bit predictor issues at fetch and matches each one, in order, against the actual outcome reported by execute. On each match it returns the actual outcome to the predictor as its training `result`. On a mismatch it raises a mispredict pulse and discards all younger (wrong-path) predictions.

## Interface
- `DEPTH`, 4: in-flight prediction queue depth; power of 2, ≥2.
- `PC_W`, 8: width of the branch index carried with each prediction.
- `CNT_W`, 16: width of the statistics counters.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `pred_valid` in 1: predictor presents a prediction for a fetched branch.
- `pred_taken` in 1: predicted direction; 1 = taken.
- `pred_pc` in PC_W: branch index of the prediction.
- `pred_ready` out 1: queue can accept a prediction.
- `res_valid` in 1: execute presents the outcome of the oldest unresolved branch.
- `res_taken` in 1: actual direction; 1 = taken.
- `res_ready` out 1: queue holds at least one prediction.
- `upd_valid` out 1: one-cycle training pulse to the predictor.
- `upd_taken` out 1: actual outcome; drives the predictor `result` input.
- `upd_pc` out PC_W: index of the resolved branch.
- `mispredict` out 1: one-cycle pulse, coincident with `upd_valid`, when prediction ≠ outcome.
- `inflight` out $clog2(DEPTH)+1: current queue occupancy.
- `br_count` out CNT_W: resolved-branch count.
- `mis_count` out CNT_W: mispredict count.

## Operation
- Circular FIFO of {taken, pc} entries; read pointer, write pointer and occupancy count.
- Push when `pred_valid && pred_ready`. `pred_ready = (inflight != DEPTH)`.
- Full queue: `pred_ready` = 0, even if a pop happens in the same cycle. There is no pass-through.
- Pop when `res_valid && res_ready`. `res_ready = (inflight != 0)`.
- `res_valid` while empty is ignored: no update and no counter change.
- On pop:
  - register `upd_valid`=1, `upd_taken`=`res_taken`, `upd_pc`=head pc.
  - `mispredict` = head.taken XOR `res_taken`.
- Pop without mismatch:
  - occupancy -1, or unchanged if a push occurs in the same cycle.
  - A simultaneous push and pop are both performed.
- Pop with mismatch (flush):
  - all remaining entries are discarded, as is any push accepted in the same cycle.
  - Next cycle: `inflight`=0 and read pointer = write pointer.
  - The push handshake still completes from the producer's view.
- Pointers wrap modulo DEPTH.
- Counters on each pop: `br_count` +1; `mis_count` +1 if mismatch. Both saturate at all-ones.
- Reset mid-operation discards all entries immediately. Any pending update pulse is dropped.

## Timing
- Reset values: `pred_ready`=1, `res_ready`=0, `upd_valid`=0, `upd_taken`=0, `upd_pc`=0, `mispredict`=0, `inflight`=0, `br_count`=0, `mis_count`=0.
- `pred_ready` and `res_ready` are decoded combinationally from registered occupancy. They do not depend on same-cycle valids.
- Pop-to-update latency is 1 cycle. `upd_*` and `mispredict` are registered and high exactly one cycle per pop.
- `inflight`, `br_count` and `mis_count` reflect a handshake on the following cycle, aligned with `upd_valid`.
- Back-to-back pops produce back-to-back `upd_valid` pulses.
- A push accepted in cycle N can be popped in cycle N+1 at the earliest.

## Configuration
- `BRU_STATS_EN` defined: `br_count` and `mis_count` are implemented as described.
- `BRU_STATS_EN` undefined: no counter registers; `br_count` and `mis_count` are tied to 0. All other behaviour is unchanged.

## Test plan
- Reset → all outputs at their reset values; then push taken@pc 0x12 and pop with `res_taken`=1 → next cycle `upd_valid`=1, `upd_taken`=1, `upd_pc`=0x12, `mispredict`=0, `br_count`=1.
- Push 4 entries with DEPTH=4 → `pred_ready`=0 and `inflight`=4. A fifth `pred_valid` is not accepted, even with a simultaneous pop.
- Push {T@1, T@2, N@3}, then pop with `res_taken`=0 → `mispredict`=1, `upd_pc`=1, `mis_count`=1, `inflight`=0 next cycle, `res_ready`=0.
- Assert `res_valid` on an empty queue → no `upd_valid`, counters unchanged. Simultaneous push and non-mispredict pop at `inflight`=2 → `inflight` stays 2.
- Push 6, pop 6 in order with matching outcomes → pointers wrap, `upd_pc` sequence matches push order, `br_count`=6, `mis_count`=0.
- Assert `rst` for 1 cycle while holding 3 entries → `inflight`=0 and counters 0 immediately (asynchronous), with no stale `upd_valid` afterwards. With `BRU_STATS_EN` undefined, the counters read 0 throughout.
